pwm_multicanal: RTL and testbench
=================================

PWM_MULTICANAL -- requirements
Module: pwm_multicanal

Interface
REQ-001 Parameter R, default 8, counter and duty width in bits.
REQ-002 Parameter N, default 4, number of PWM channels.
REQ-003 Parameter D, default 8, pattern table depth in steps; AW = clog2(D), minimum 1.
REQ-004 Parameter PW, default 8, prescaler width in bits.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 presc  input  PW  prescaler divisor; counter advances once every presc+1 clk cycles.
REQ-008 start  input  1  single-cycle pulse; begins the sequence.
REQ-009 stop  input  1  single-cycle pulse; requests a stop at the end of the current period.
REQ-010 last_step  input  AW  index of the final step in the sequence.
REQ-011 wr_en  input  1  pattern table write strobe.
REQ-012 wr_addr  input  AW  pattern table write address.
REQ-013 wr_data  input  N*R  duty values; channel i occupies bits [i*R+R-1 : i*R].
REQ-014 pwm_out  output  N  PWM outputs, registered.
REQ-015 tick  output  1  one-cycle pulse at each period end while running.
REQ-016 step_idx  output  AW  step currently driving the outputs.
REQ-017 busy  output  1  high in RUN and DRAIN.

Function
REQ-018 Prescaler: pcnt counts 0..presc, then wraps; en = (pcnt==presc); presc=0 gives en on every cycle.
REQ-019 A presc change takes effect at the next pcnt wrap; if pcnt > the new presc, pcnt wraps to 0 on the next cycle.
REQ-020 Period counter Q (R bits) increments on en and wraps 2^R-1 -> 0; pend = en & (Q == 2^R-1).
REQ-021 FSM states: IDLE, RUN, DRAIN.
REQ-022 In IDLE, pcnt and Q are held at 0.
REQ-023 IDLE + start -> RUN next cycle; the same edge sets step_idx=0 and loads the duty shadows from table[0].
REQ-024 RUN + stop -> DRAIN; start is ignored in RUN and DRAIN, and stop is ignored in IDLE.
REQ-025 Simultaneous start and stop in IDLE: start wins.
REQ-026 RUN + pend: step_idx becomes (step_idx == last_step) ? 0 : step_idx+1, and the shadows load from the new step on the same edge.
REQ-027 A last_step value >= D is treated as D-1.
REQ-028 DRAIN + pend -> IDLE.
REQ-029 tick is asserted for one cycle on every pend in RUN and in DRAIN.
REQ-030 pwm_out[i] = 1 iff the state is RUN or DRAIN and Q < shadow[i], registered with one cycle of latency.
REQ-031 Duty 0 gives a constant low output; duty 2^R-1 gives high for 2^R-1 of 2^R counts.
REQ-032 Duty shadows change only at pend or start, so no mid-period glitches occur.
REQ-033 Table writes are synchronous and allowed in any state.
REQ-034 A write and a shadow load of the same address on the same cycle: the load takes the old contents (read-before-write).
REQ-035 Writes with wr_addr >= D are ignored.
REQ-036 All pwm_out bits are 0 in IDLE.

Reset
REQ-037 Reset assertion immediately forces: state IDLE, pcnt=0, Q=0, step_idx=0, shadows=0, pwm_out=0, tick=0, busy=0.
REQ-038 Pattern table contents are cleared to 0 on reset.
REQ-039 Reset mid-period aborts the current period with no completion tick.
REQ-040 Outputs leave their reset values only after the first clk edge following deassertion.

Configuration
REQ-041 Macro PWM_MULTICANAL_ONESHOT_EN, when defined, adds input port oneshot (1 bit).
REQ-042 With the macro defined and oneshot=1: a pend in RUN at step_idx == last_step goes to IDLE instead of wrapping, and a tick is still issued.
REQ-043 With the macro defined and oneshot=0, or with the macro undefined, the sequence loops per REQ-026; no oneshot port exists when undefined.

Verification
REQ-044 R=8, presc=0, table[0]={0x80,0x00,0xFF,0x40}, last_step=0, start: pwm_out high counts per 256 = 128/0/255/64; tick every 256 clk.
REQ-045 presc=3: pwm_out[0] period = 1024 clk; tick spacing = 1024 clk.
REQ-046 last_step=2, three distinct steps: step_idx cycles 0,1,2,0; duty changes exactly at tick; no runt pulses.
REQ-047 stop at Q=10: outputs keep running until Q wraps, then one tick, busy=0, pwm_out=0.
REQ-048 Write table[1] on the cycle of the pend that loads step 1: the old value is used this pass and the new value on the next pass.
REQ-049 reset low at Q=100 in RUN: all outputs 0 at once, table reads 0 after release; oneshot=1 (macro defined) with last_step=1 returns to IDLE after two ticks.

Source files
------------

// File: rtl/pwm_multicanal.sv
// pwm_multicanal: N-channel PWM sequencer that steps through a duty-pattern table once per counter period.
// Define PWM_MULTICANAL_ONESHOT_EN to add the oneshot input (stop after the last step instead of looping).
module pwm_multicanal #(
  parameter int R  = 8,
  parameter int N  = 4,
  parameter int D  = 8,
  parameter int PW = 8,
  localparam int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [PW-1:0]  presc,
  input  logic           start,
  input  logic           stop,
  input  logic [AW-1:0]  last_step,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [N*R-1:0] wr_data,
`ifdef PWM_MULTICANAL_ONESHOT_EN
  input  logic           oneshot,
`endif
  output logic [N-1:0]   pwm_out,
  output logic           tick,
  output logic [AW-1:0]  step_idx,
  output logic           busy
);
  localparam int TD = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t         r_state, w_state_nxt;
  logic [PW-1:0]  r_pcnt;
  logic [R-1:0]   r_q;
  logic [AW-1:0]  r_step;
  logic [N*R-1:0] r_shadow;
  logic [N*R-1:0] r_tab [TD];
  logic [N-1:0]   r_pwm;

  logic           w_run, w_en, w_pend, w_oneshot, w_seq_end, w_load, w_wr_ok;
  logic [AW-1:0]  w_last, w_nxt_idx, w_load_idx;
  logic [N-1:0]   w_cmp;

  // Table rows at or above D are never written, so they read back as zero.
  if (TD > D) begin : g_clamp
    localparam logic [AW-1:0] LAST_MAX = AW'(D - 1);
    assign w_last  = (last_step > LAST_MAX) ? LAST_MAX : last_step;
    assign w_wr_ok = wr_en && (wr_addr <= LAST_MAX);
  end else begin : g_full
    assign w_last  = last_step;
    assign w_wr_ok = wr_en;
  end

`ifdef PWM_MULTICANAL_ONESHOT_EN
  assign w_oneshot = oneshot;
`else
  assign w_oneshot = 1'b0;
`endif

  assign w_run     = (r_state != S_IDLE);
  assign w_en      = w_run && (r_pcnt == presc);
  assign w_pend    = w_en && (r_q == '1);
  assign w_seq_end = (r_step == w_last);
  assign w_nxt_idx = w_seq_end ? '0 : r_step + AW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = w_nxt_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
          w_load_idx  = '0;
        end
      end
      S_RUN: begin
        if (w_pend && w_oneshot && w_seq_end) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_load = w_pend;
          if (stop) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pend) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < N; i++) w_cmp[i] = w_run && (r_q < r_shadow[i*R +: R]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A prescaler shrunk below the current count wraps on the next cycle without an enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt   <= '0;
      r_q      <= '0;
      r_step   <= '0;
      r_shadow <= '0;
      r_pwm    <= '0;
    end else begin
      if (!w_run) begin
        r_pcnt <= '0;
        r_q    <= '0;
      end else begin
        r_pcnt <= (r_pcnt >= presc) ? '0 : r_pcnt + PW'(1);
        if (w_en) r_q <= r_q + R'(1);
      end
      if (w_load) begin
        r_step   <= w_load_idx;
        r_shadow <= r_tab[w_load_idx];
      end
      r_pwm <= w_cmp;
    end
  end

  // Shadow loads read the old row when a write hits the same address in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TD; k++) r_tab[k] <= '0;
    end else if (w_wr_ok) begin
      r_tab[wr_addr] <= wr_data;
    end
  end

  assign pwm_out  = r_pwm;
  assign tick     = w_pend;
  assign step_idx = r_step;
  assign busy     = w_run;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Self-checking bench for pwm_multicanal: directed scenarios plus randomized runs
// compared every cycle against an elapsed-time reference model.
module tb_pwm_multicanal;
  localparam int R  = 8;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int PW = 8;
  localparam int AW = 3;
  localparam int QN = 1 << R;

  logic           clk = 1'b0;
  logic           reset;
  logic [PW-1:0]  presc;
  logic           start;
  logic           stop;
  logic [AW-1:0]  last_step;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [N*R-1:0] wr_data;
`ifdef PWM_MULTICANAL_ONESHOT_EN
  logic           oneshot;
`endif
  logic [N-1:0]   pwm_out;
  logic           tick;
  logic [AW-1:0]  step_idx;
  logic           busy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: run status, elapsed cycles since the run began, step and duties.
  bit             m_busy;
  bit             m_drain;
  int             m_e;
  int             m_step;
  logic [N*R-1:0] m_sh;
  logic [N*R-1:0] m_tab [D];
  logic [N-1:0]   m_pwm;

  int m_hi [N];
  int t1, t2, r1, r2;

  always #5 clk = ~clk;

  pwm_multicanal #(.R(R), .N(N), .D(D), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .presc     (presc),
    .start     (start),
    .stop      (stop),
    .last_step (last_step),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef PWM_MULTICANAL_ONESHOT_EN
    .oneshot   (oneshot),
`endif
    .pwm_out   (pwm_out),
    .tick      (tick),
    .step_idx  (step_idx),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_drain = 0;
    m_e     = 0;
    m_step  = 0;
    m_sh    = '0;
    m_pwm   = '0;
    for (int a = 0; a < D; a++) m_tab[a] = '0;
  endtask

  task automatic check_outputs();
    int pp;
    int per;
    pp  = int'(presc) + 1;
    per = QN * pp;
    chk("busy", busy, m_busy);
    chk("tick", tick, (m_busy && (m_e % per == per - 1)));
    chk("step", step_idx, m_step);
    chk("pwm", pwm_out, m_pwm);
  endtask

  task automatic model_edge();
    int pp, per, q, lc;
    bit pend, os;
    logic [N-1:0] np;
    pp   = int'(presc) + 1;
    per  = QN * pp;
    q    = (m_e / pp) % QN;
    pend = m_busy && (m_e % per == per - 1);
    lc   = int'(last_step);
    if (lc > D - 1) lc = D - 1;
`ifdef PWM_MULTICANAL_ONESHOT_EN
    os = oneshot;
`else
    os = 0;
`endif
    for (int i = 0; i < N; i++) np[i] = m_busy && (q < int'(m_sh[i*R +: R]));
    if (!m_busy) begin
      if (start) begin
        m_busy  = 1;
        m_drain = 0;
        m_e     = 0;
        m_step  = 0;
        m_sh    = m_tab[0];
      end
    end else if (pend && m_drain) begin
      m_busy = 0;
    end else if (pend && os && m_step == lc) begin
      m_busy = 0;
    end else begin
      if (pend) begin
        m_step = (m_step == lc) ? 0 : m_step + 1;
        m_sh   = m_tab[m_step];
      end
      if (stop) m_drain = 1;
      m_e++;
    end
    if (wr_en && int'(wr_addr) < D) m_tab[wr_addr] = wr_data;
    m_pwm = np;
  endtask

  task automatic run_cycle();
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wr_entry(input int a, input logic [N*R-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    run_cycle();
  endtask

  task automatic do_start();
    start = 1'b1;
    run_cycle();
  endtask

  task automatic go_idle();
    stop = 1'b1;
    run_cycle();
    for (int k = 0; k < 4096 && m_busy; k++) run_cycle();
    chk("idle_reached", busy, 0);
  endtask

  task automatic measure(input int ncyc, input int w0, input int w1);
    logic prev0;
    prev0 = 1'b0;
    for (int i = 0; i < N; i++) m_hi[i] = 0;
    t1 = -1; t2 = -1; r1 = -1; r2 = -1;
    for (int j = 0; j < ncyc; j++) begin
      if (j >= w0 && j < w1)
        for (int i = 0; i < N; i++) if (pwm_out[i]) m_hi[i]++;
      if (tick) begin
        if (t1 < 0) t1 = j;
        else if (t2 < 0) t2 = j;
      end
      if (pwm_out[0] && !prev0) begin
        if (r1 < 0) r1 = j;
        else if (r2 < 0) r2 = j;
      end
      prev0 = pwm_out[0];
      run_cycle();
    end
  endtask

  function automatic logic [N*R-1:0] rand_row();
    logic [N*R-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      case ($urandom_range(0, 3))
        0:       v[i*R +: R] = '0;
        1:       v[i*R +: R] = '1;
        default: v[i*R +: R] = R'($urandom);
      endcase
    return v;
  endfunction

  initial begin
    int ticks;
    reset = 1'b0; presc = '0; start = 1'b0; stop = 1'b0;
    last_step = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef PWM_MULTICANAL_ONESHOT_EN
    oneshot = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_step", step_idx, 0);
    reset = 1'b1;
    run_cycle();
    run_cycle();

    // Single step, presc 0: high counts and tick spacing.
    wr_entry(0, {8'h40, 8'hFF, 8'h00, 8'h80});
    last_step = '0;
    do_start();
    measure(520, 1, 257);
    chk("duty_ch0", m_hi[0], 128);
    chk("duty_ch1", m_hi[1], 0);
    chk("duty_ch2", m_hi[2], 255);
    chk("duty_ch3", m_hi[3], 64);
    chk("tick_first", t1, 255);
    chk("tick_space", t2 - t1, 256);
    go_idle();

    // presc 3: period and tick spacing of 1024 clocks.
    presc = 8'd3;
    do_start();
    measure(2100, 1, 1025);
    chk("p3_ch0", m_hi[0], 512);
    chk("p3_ch2", m_hi[2], 1020);
    chk("p3_ch3", m_hi[3], 256);
    chk("p3_tick_space", t2 - t1, 1024);
    chk("p3_pwm_period", r2 - r1, 1024);
    go_idle();
    presc = '0;

    // Three-step sequence loops 0,1,2,0.
    wr_entry(0, 32'h11223344);
    wr_entry(1, 32'hA0B0C0D0);
    wr_entry(2, 32'h05F00F50);
    last_step = 3'd2;
    do_start();
    for (int j = 0; j < 900; j++) begin
      if (j % 256 == 100) chk("seq_step", step_idx, (j / 256) % 3);
      run_cycle();
    end
    go_idle();

    // Stop at Q=10 drains to the end of the period.
    last_step = '0;
    do_start();
    for (int j = 0; j < 10; j++) run_cycle();
    stop = 1'b1;
    run_cycle();
    for (int j = 11; j < 256; j++) begin
      if (j == 200) chk("drain_busy", busy, 1);
      if (j == 255) chk("drain_tick", tick, 1);
      run_cycle();
    end
    chk("stop_busy", busy, 0);
    run_cycle();
    chk("stop_pwm", pwm_out, 0);

    // Write to row 1 on the pend that loads it: old value this pass, new value next pass.
    wr_entry(0, 32'h10203040);
    wr_entry(1, 32'h50607080);
    last_step = 3'd1;
    do_start();
    for (int j = 0; j < 255; j++) run_cycle();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'hC0B0A090;
    run_cycle();
    measure(257, 1, 257);
    chk("rbw_old", m_hi[0], 8'h80);
    for (int j = 0; j < 256; j++) run_cycle();
    measure(256, 0, 256);
    chk("rbw_new", m_hi[0], 8'h90);
    go_idle();

    // Reset at Q=100 while running clears outputs and the table.
    wr_entry(0, 32'h7F7F7F7F);
    last_step = '0;
    do_start();
    for (int j = 0; j < 100; j++) run_cycle();
    reset = 1'b0;
    #1;
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_step", step_idx, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    do_start();
    measure(300, 1, 257);
    for (int i = 0; i < N; i++) chk("tab_cleared", m_hi[i], 0);
    go_idle();

`ifdef PWM_MULTICANAL_ONESHOT_EN
    wr_entry(0, 32'h80808080);
    wr_entry(1, 32'h40404040);
    last_step = 3'd1;
    oneshot = 1'b1;
    do_start();
    ticks = 0;
    for (int k = 0; k < 1200 && m_busy; k++) begin
      if (tick) ticks++;
      run_cycle();
    end
    chk("os_ticks", ticks, 2);
    chk("os_idle", busy, 0);
    oneshot = 1'b0;
`endif

    // Randomized runs with live table writes, stray starts and random stops.
    for (int r = 0; r < 6; r++) begin
      presc = PW'($urandom_range(0, 1));
      last_step = AW'($urandom_range(0, D - 1));
      for (int a = 0; a < D; a++) wr_entry(a, rand_row());
      do_start();
      for (int k = 0; k < 3 * QN * (int'(presc) + 1); k++) begin
        if ($urandom_range(0, 7) == 0) begin
          wr_en = 1'b1;
          wr_addr = AW'($urandom_range(0, D - 1));
          wr_data = rand_row();
        end
        if ($urandom_range(0, 599) == 0) stop = 1'b1;
        if ($urandom_range(0, 99) == 0) start = 1'b1;
        run_cycle();
      end
      go_idle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
